// File: rtl/apb2_pin_mux_regs.sv
// APB2 register bank holding a double-buffered pin-mux select table.
// Shadow entries are programmed freely; a CTRL commit copies them to the active table atomically.
module apb2_pin_mux_regs #(
    parameter int ADDR_BYTES = 1,
    parameter int PIN_COUNT  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_BYTES*8-1:0] PADDR,
    input  logic                   PSEL,
    input  logic                   PENABLE,
    input  logic                   PWRITE,
    input  logic [7:0]             PWDATA,
    output logic [7:0]             PRDATA,
    output logic [PIN_COUNT*8-1:0] mux_sel,
    output logic                   commit_pulse
);
    localparam int AW = ADDR_BYTES * 8;

    generate
        if ((PIN_COUNT < 1) || (PIN_COUNT > 64)) begin : g_bad_pin_count
            $error("apb2_pin_mux_regs: PIN_COUNT must be in 1..64");
        end
    endgenerate

    logic [PIN_COUNT-1:0][7:0] r_shadow;
    logic [PIN_COUNT-1:0][7:0] r_active;
    logic [7:0]                r_prdata;
    logic [7:0]                r_scratch;
    logic [7:0]                r_wrcount;
    logic                      r_pending;
    logic                      r_setup_seen;
    logic                      r_commit_pulse;

    logic                      w_hit;
    logic [7:0]                w_lo;
    logic                      w_setup;
    logic                      w_wr;
    logic [7:0]                w_rdata;

    // Any address bit above the low byte set means the access is not for us.
    assign w_hit   = ((PADDR >> 8) == AW'(0));
    assign w_lo    = PADDR[7:0];
    assign w_setup = PSEL & ~PENABLE;
    assign w_wr    = PSEL & PENABLE & r_setup_seen & PWRITE & w_hit;

    always_comb begin
        w_rdata = 8'h00;
        if (w_hit) begin
            case (w_lo)
                8'h00:   w_rdata = 8'hA5;
                8'h01:   w_rdata = {7'b0, r_pending};
                8'h03:   w_rdata = r_scratch;
                8'h04:   w_rdata = r_wrcount;
                default: begin
                    for (int i = 0; i < PIN_COUNT; i++) begin
                        if (w_lo == 8'(16 + i))  w_rdata = r_shadow[i];
                        if (w_lo == 8'(128 + i)) w_rdata = r_active[i];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow       <= '1;
            r_active       <= '1;
            r_prdata       <= 8'h00;
            r_scratch      <= 8'h00;
            r_wrcount      <= 8'h00;
            r_pending      <= 1'b0;
            r_setup_seen   <= 1'b0;
            r_commit_pulse <= 1'b0;
        end else begin
            r_commit_pulse <= 1'b0;
            if (w_setup) begin
                r_setup_seen <= 1'b1;
                r_prdata     <= w_rdata;
            end else if (PSEL && PENABLE) begin
                // Clearing here makes a held PENABLE a no-op after the first edge.
                r_setup_seen <= 1'b0;
            end

            if (w_wr) begin
                case (w_lo)
                    8'h02: begin
                        if (PWDATA[0]) begin
                            r_active       <= r_shadow;
                            r_commit_pulse <= 1'b1;
                            r_pending      <= 1'b0;
                            r_wrcount      <= 8'h00;
                        end else if (PWDATA[1]) begin
                            r_shadow  <= r_active;
                            r_pending <= 1'b0;
                            r_wrcount <= 8'h00;
                        end
                    end
                    8'h03:   r_scratch <= PWDATA;
                    default: begin
                        for (int i = 0; i < PIN_COUNT; i++) begin
                            if (w_lo == 8'(16 + i)) begin
                                r_shadow[i] <= PWDATA;
                                r_pending   <= 1'b1;
                                if (r_wrcount != 8'hFF) r_wrcount <= r_wrcount + 8'd1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign PRDATA       = r_prdata;
    assign mux_sel      = r_active;
    assign commit_pulse = r_commit_pulse;
endmodule

// File: tb/tb_apb2_pin_mux_regs.sv
// Directed bench for apb2_pin_mux_regs with hand-computed expectations.
module tb_apb2_pin_mux_regs;
    localparam int AB = 2;
    localparam int PC = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [AB*8-1:0] PADDR;
    logic            PSEL, PENABLE, PWRITE;
    logic [7:0]      PWDATA;
    logic [7:0]      PRDATA;
    logic [PC*8-1:0] mux_sel;
    logic            commit_pulse;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    apb2_pin_mux_regs #(.ADDR_BYTES(AB), .PIN_COUNT(PC)) dut (
        .clk(clk), .rst(rst), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .mux_sel(mux_sel),
        .commit_pulse(commit_pulse)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (commit_pulse === 1'b1) pulse_cnt++;

    task automatic apb_write(input logic [15:0] a, input logic [7:0] d, input int hold = 1);
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(negedge clk);
        PENABLE = 1'b1;
        repeat (hold) @(negedge clk);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [15:0] a, output logic [7:0] d);
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(negedge clk);
        PENABLE = 1'b1;
        @(negedge clk);
        d = PRDATA;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++; if (mux_sel !== {PC{8'hFF}}) begin errors++; $display("FAIL reset_mux: got %h want all ff", mux_sel); end
        checks++; if (PRDATA !== 8'h00) begin errors++; $display("FAIL reset_prdata: got %h want 00", PRDATA); end
        checks++; if (commit_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b want 0", commit_pulse); end
        apb_read(16'h0000, d);
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL read_id: got %h want a5", d); end
        apb_read(16'h0005, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL read_unmapped: got %h want 00", d); end
        apb_read(16'h0000, d);
        apb_read(16'h0100, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL read_hi_bit: got %h want 00", d); end
        apb_read(16'h0110, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL read_hi_alias: got %h want 00", d); end
        apb_read(16'h0010, d);
        checks++; if (d !== 8'hFF) begin errors++; $display("FAIL reset_shadow: got %h want ff", d); end
    endtask

    task automatic test_shadow_write();
        logic [7:0] d;
        apb_write(16'h0010, 8'h03);
        apb_write(16'h0011, 8'h07);
        checks++; if (mux_sel !== {PC{8'hFF}}) begin errors++; $display("FAIL shadow_no_mux: got %h want all ff", mux_sel); end
        apb_read(16'h0001, d);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL status_pending: got %h want 01", d); end
        apb_read(16'h0004, d);
        checks++; if (d !== 8'h02) begin errors++; $display("FAIL wrcount_2: got %h want 02", d); end
        apb_read(16'h0010, d);
        checks++; if (d !== 8'h03) begin errors++; $display("FAIL shadow0: got %h want 03", d); end
        apb_read(16'h0011, d);
        checks++; if (d !== 8'h07) begin errors++; $display("FAIL shadow1: got %h want 07", d); end
        apb_read(16'h0080, d);
        checks++; if (d !== 8'hFF) begin errors++; $display("FAIL active0_pre: got %h want ff", d); end
        // Writes to read-only and unmapped locations must be dropped.
        apb_write(16'h0000, 8'h11);
        apb_write(16'h0080, 8'h22);
        apb_write(16'h0110, 8'h33);
        apb_read(16'h0000, d);
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL ro_id: got %h want a5", d); end
        apb_read(16'h0080, d);
        checks++; if (d !== 8'hFF) begin errors++; $display("FAIL ro_active: got %h want ff", d); end
        apb_read(16'h0010, d);
        checks++; if (d !== 8'h03) begin errors++; $display("FAIL hi_alias_wr: got %h want 03", d); end
    endtask

    task automatic test_commit();
        logic [7:0] d;
        int c0;
        c0 = pulse_cnt;
        apb_write(16'h0002, 8'h01);
        checks++; if (commit_pulse !== 1'b1) begin errors++; $display("FAIL commit_pulse_hi: got %b want 1", commit_pulse); end
        checks++; if (mux_sel[15:0] !== 16'h0703) begin errors++; $display("FAIL commit_mux: got %h want 0703", mux_sel[15:0]); end
        checks++; if (mux_sel[PC*8-1:16] !== {(PC-2){8'hFF}}) begin errors++; $display("FAIL commit_mux_rest: got %h want all ff", mux_sel[PC*8-1:16]); end
        @(negedge clk);
        checks++; if (commit_pulse !== 1'b0) begin errors++; $display("FAIL commit_pulse_lo: got %b want 0", commit_pulse); end
        checks++; if (pulse_cnt - c0 !== 1) begin errors++; $display("FAIL commit_pulse_cnt: got %0d want 1", pulse_cnt - c0); end
        apb_read(16'h0001, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL status_clear: got %h want 00", d); end
        apb_read(16'h0004, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL wrcount_clear: got %h want 00", d); end
        apb_read(16'h0081, d);
        checks++; if (d !== 8'h07) begin errors++; $display("FAIL active1: got %h want 07", d); end
        apb_read(16'h0002, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL ctrl_read: got %h want 00", d); end
    endtask

    task automatic test_revert();
        logic [7:0] d;
        int c0;
        c0 = pulse_cnt;
        apb_write(16'h0010, 8'h09);
        apb_write(16'h0002, 8'h02);
        apb_read(16'h0010, d);
        checks++; if (d !== 8'h03) begin errors++; $display("FAIL revert_shadow: got %h want 03", d); end
        checks++; if (pulse_cnt !== c0) begin errors++; $display("FAIL revert_no_pulse: got %0d want %0d", pulse_cnt, c0); end
        checks++; if (mux_sel[15:0] !== 16'h0703) begin errors++; $display("FAIL revert_mux: got %h want 0703", mux_sel[15:0]); end
        apb_read(16'h0001, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL revert_status: got %h want 00", d); end
        apb_write(16'h0010, 8'h09);
        apb_write(16'h0002, 8'h03);
        @(negedge clk);
        checks++; if (mux_sel[15:0] !== 16'h0709) begin errors++; $display("FAIL both_commit_mux: got %h want 0709", mux_sel[15:0]); end
        checks++; if (pulse_cnt - c0 !== 1) begin errors++; $display("FAIL both_pulse: got %0d want 1", pulse_cnt - c0); end
        apb_write(16'h0010, 8'h0A);
        apb_write(16'h0002, 8'h00);
        apb_read(16'h0001, d);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL ctrl00_status: got %h want 01", d); end
        checks++; if (mux_sel[7:0] !== 8'h09) begin errors++; $display("FAIL ctrl00_mux: got %h want 09", mux_sel[7:0]); end
    endtask

    task automatic test_hold_and_saturate();
        logic [7:0] d;
        apb_read(16'h0004, d);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL wrcount_pre: got %h want 01", d); end
        apb_write(16'h0012, 8'h55, 3);
        apb_read(16'h0004, d);
        checks++; if (d !== 8'h02) begin errors++; $display("FAIL held_penable: got %h want 02", d); end
        for (int k = 0; k < 300; k++) apb_write(16'h0013, 8'(k));
        apb_read(16'h0004, d);
        checks++; if (d !== 8'hFF) begin errors++; $display("FAIL wrcount_sat: got %h want ff", d); end
        apb_read(16'h0013, d);
        checks++; if (d !== 8'h2B) begin errors++; $display("FAIL last_shadow: got %h want 2b", d); end
        apb_read(16'h008F, d);
        checks++; if (d !== 8'hFF) begin errors++; $display("FAIL active15: got %h want ff", d); end
        apb_read(16'h0090, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL past_active: got %h want 00", d); end
        repeat (4) @(negedge clk);
        checks++; if (PRDATA !== 8'h00) begin errors++; $display("FAIL prdata_hold: got %h want 00", PRDATA); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h0003; PWDATA = 8'h11;
        @(negedge clk); PENABLE = 1'b1;
        @(negedge clk); PENABLE = 1'b0; PWRITE = 1'b0;
        @(negedge clk); PENABLE = 1'b1;
        checks++; if (PRDATA !== 8'h11) begin errors++; $display("FAIL b2b_scratch: got %h want 11", PRDATA); end
        @(negedge clk); PSEL = 1'b0; PENABLE = 1'b0;
        // Commit then STATUS setup immediately after the commit edge.
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h0002; PWDATA = 8'h01;
        @(negedge clk); PENABLE = 1'b1;
        @(negedge clk); PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 16'h0001;
        @(negedge clk); PENABLE = 1'b1;
        checks++; if (PRDATA !== 8'h00) begin errors++; $display("FAIL b2b_status: got %h want 00", PRDATA); end
        @(negedge clk); PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic test_reset_mid_transfer();
        logic [7:0] d;
        apb_read(16'h0000, d);
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h0003; PWDATA = 8'h44;
        @(negedge clk); PENABLE = 1'b1;
        rst = 1'b1;
        #1;
        checks++; if (PRDATA !== 8'h00) begin errors++; $display("FAIL async_prdata: got %h want 00", PRDATA); end
        checks++; if (mux_sel !== {PC{8'hFF}}) begin errors++; $display("FAIL async_mux: got %h want all ff", mux_sel); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        apb_read(16'h0003, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL orphan_access: got %h want 00", d); end
        apb_read(16'h0004, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_wrcount: got %h want 00", d); end
        apb_read(16'h0010, d);
        checks++; if (d !== 8'hFF) begin errors++; $display("FAIL rst_shadow: got %h want ff", d); end
        apb_write(16'h0003, 8'h5A);
        apb_read(16'h0003, d);
        checks++; if (d !== 8'h5A) begin errors++; $display("FAIL scratch_rw: got %h want 5a", d); end
    endtask

    initial begin
        test_reset();
        test_shadow_write();
        test_commit();
        test_revert();
        test_hold_and_saturate();
        test_back_to_back();
        test_reset_mid_transfer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
